bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares the single-port weight/image BRAM between two requesters: m0 = host loader
//  (writes weights/pixels), m1 = compute engine (reads operands). Grants one access per cycle,
//  drives BRAM en/addr/we/wdata, returns 1-cycle-latency read data tagged to its requester.
//  Supports a lock so a burst (e.g. a full image load) owns the port, with a bounded hold.
// PARAMETERS
//  ADDR_W    32  byte-address width; forwarded unmodified, BRAM uses addr>>2
//  DATA_W    32  word width
//  LOCK_MAX  64  max consecutive accepted beats under lock before forced release (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  mN_req     in   1       N=0,1: access request, held until accepted
//  mN_we      in   1       1=write word, 0=read
//  mN_addr    in   ADDR_W  byte address, word-aligned (addr[1:0]==0)
//  mN_wdata   in   DATA_W  write data
//  mN_lock    in   1       keep ownership after this beat
//  mN_gnt     out  1       combinational; beat accepted when mN_req && mN_gnt
//  mN_rvalid  out  1       registered; read data valid
//  mN_rdata   out  DATA_W  = bram_rdata; meaningful only when mN_rvalid
//  bram_en    out  1       BRAM enable (required for both read and write)
//  bram_addr  out  ADDR_W  address of accepted beat
//  bram_we    out  4       4'b1111 on accepted write, else 4'b0000
//  bram_wdata out  DATA_W  write data of accepted beat
//  bram_rdata in   DATA_W  BRAM registered read data
// BEHAVIOUR
//  - FSM: IDLE, OWN0, OWN1. Grant: IDLE -> arbitration pick; OWNx -> only x may be granted.
//  - At most one gnt per cycle; gnt never asserted without req. bram_en = |(mN_req & mN_gnt);
//    bram_addr/we/wdata muxed from granted requester, zero when no grant.
//  - Accepted beat with lock=1: go/stay OWNx, lock_cnt++. lock=0 beat: -> IDLE.
//    In OWNx with req=0 && lock=0: -> IDLE next cycle (no beat). req=0 && lock=1: stay, idle port.
//  - lock_cnt reaching LOCK_MAX on an accepted beat: force IDLE for >=1 cycle regardless of lock;
//    other requester wins that arbitration if requesting. lock_cnt clears on entry to IDLE.
//  - Read latency: accepted read at edge k -> mN_rvalid=1 for exactly the cycle after edge k;
//    owner tag registered with the beat. Writes produce no rvalid. Back-to-back reads: 1/cycle.
//  - Simultaneous: read response of prior beat and new grant to other requester coexist.
//  - Unaligned addr: forwarded as-is (BRAM truncates); sim-only $error under assertions.
//  - Reset (async, mid-op included): state=IDLE, lock_cnt=0, rr_ptr=0, mN_rvalid=0;
//    in-flight read response discarded; gnt/bram_en low while rst=0.
// CONFIGURATION
//  BRAM_ARB_RR_EN defined: IDLE arbitration round-robin; rr_ptr flips to the other requester
//   after each grant issued from IDLE. Undefined: fixed priority, m0 beats m1 always.
//  Lock and LOCK_MAX behaviour identical in both builds.
// STRUCTURE
//  Package mnist_mem_pkg: ADDR_W/DATA_W defaults, BRAM_WE_FULL=4'b1111, typedef enum
//   arb_state_t {IDLE,OWN0,OWN1}, typedef enum req_id_t {REQ_HOST,REQ_CORE}.
//  Sub-module arb_pick2 (combinational 2-way picker: fixed or rr_ptr-based); state, lock
//   counter and response tag stay in top.
// TESTING
//  1 m0 write addr 0x10 data 0xCAFE, then m1 read 0x10 -> bram_we=1111 then m1_rvalid 1 cycle
//    after accept with rdata=0xCAFE; m0_rvalid stays 0.
//  2 both req reads every cycle from IDLE, no lock -> RR build: grants alternate m0,m1,m0...;
//    fixed build: m0 only until m0_req drops; never two gnt in one cycle.
//  3 m0 lock=1 burst of 10 writes while m1_req held -> m1_gnt=0 throughout; m1 granted cycle
//    after m0's lock=0 beat.
//  4 LOCK_MAX=4, m0 lock held forever, m1 requesting -> after 4th m0 beat m1 gets one beat,
//    then m0 resumes; lock_cnt restarts at 0.
//  5 rst pulsed low the cycle after an accepted read -> no rvalid emitted, bram_en=0, FSM IDLE;
//    first post-reset grant follows rr_ptr=0 (m0 first).
//  6 OWN1 with m1 req=0, lock=1 for 3 cycles -> bram_en=0, m0_gnt=0; m1 lock drop -> IDLE.

Source files
------------

// File: rtl/mnist_mem_pkg.sv
// Shared types and defaults for the MNIST weight/image memory path.
package mnist_mem_pkg;

    localparam int         ADDR_W_DEF   = 32;
    localparam int         DATA_W_DEF   = 32;
    localparam logic [3:0] BRAM_WE_FULL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_CORE = 1'b1
    } req_id_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: the preferred requester wins when it requests,
// otherwise the other one. Fixed priority is simply pref tied to 0.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       pref,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[pref])
            gnt[pref] = 1'b1;
        else if (req[!pref])
            gnt[!pref] = 1'b1;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for the single-port weight/image BRAM with lockable bursts.
// Define BRAM_ARB_RR_EN for round-robin IDLE arbitration; otherwise m0 has fixed priority.
module bram_port_arbiter
    import mnist_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    localparam int               CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             frc_vld, frc_vld_nxt;
    req_id_t          frc_id, frc_id_nxt;
    logic [1:0]       pick, gnt, rsp_vld;
    logic             pref, beat_lock;
    req_id_t          win;

    // After a forced release the previous owner's rival gets first pick.
`ifdef BRAM_ARB_RR_EN
    logic rr_ptr;
    assign pref = frc_vld ? ~frc_id : rr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= 1'b0;
        else if (state == IDLE && |gnt)
            rr_ptr <= ~win;
    end
`else
    assign pref = frc_vld ? ~frc_id : 1'b0;
`endif

    arb_pick2 u_pick (
        .req  ({m1_req, m0_req}),
        .pref (pref),
        .gnt  (pick)
    );

    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            case (state)
                IDLE:    gnt = pick;
                OWN0:    gnt[0] = m0_req;
                OWN1:    gnt[1] = m1_req;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign win       = gnt[1] ? REQ_CORE : REQ_HOST;
    assign beat_lock = gnt[1] ? m1_lock : m0_lock;

    always_comb begin
        bram_en    = |gnt;
        bram_addr  = '0;
        bram_we    = 4'b0000;
        bram_wdata = '0;
        if (gnt[0]) begin
            bram_addr  = m0_addr;
            bram_we    = m0_we ? BRAM_WE_FULL : 4'b0000;
            bram_wdata = m0_wdata;
        end else if (gnt[1]) begin
            bram_addr  = m1_addr;
            bram_we    = m1_we ? BRAM_WE_FULL : 4'b0000;
            bram_wdata = m1_wdata;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        frc_vld_nxt  = 1'b0;
        frc_id_nxt   = frc_id;
        if (|gnt) begin
            if (beat_lock && lock_cnt == CNT_LAST) begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
                frc_vld_nxt  = 1'b1;
                frc_id_nxt   = win;
            end else if (beat_lock) begin
                state_nxt    = (win == REQ_CORE) ? OWN1 : OWN0;
                lock_cnt_nxt = lock_cnt + 1'b1;
            end else begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        end else if ((state == OWN0 && !m0_lock) || (state == OWN1 && !m1_lock)) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
            frc_vld  <= 1'b0;
            frc_id   <= REQ_HOST;
            rsp_vld  <= 2'b00;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            frc_vld  <= frc_vld_nxt;
            frc_id   <= frc_id_nxt;
            rsp_vld  <= {gnt[1] & ~m1_we, gnt[0] & ~m0_we};
        end
    end

    // The response tag is the per-requester bit in rsp_vld; data is shared.
    assign m0_rvalid = rsp_vld[0];
    assign m1_rvalid = rsp_vld[1];
    assign m0_rdata  = bram_rdata;
    assign m1_rdata  = bram_rdata;

`ifndef SYNTHESIS
    unaligned_addr: assert property (@(posedge clk) disable iff (!rst)
        bram_en |-> bram_addr[1:0] == 2'b00)
        else $error("bram_port_arbiter: unaligned address %h", bram_addr);
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus randomized
// traffic compared every cycle against an ownership-level reference model.
module tb_bram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // BRAM stand-in: registered read data, write on full byte enable.
    logic [DW-1:0] tb_mem [256];
    bit            mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bram_en) begin
            if (bram_we == 4'hF) tb_mem[bram_addr[9:2]] <= bram_wdata;
            bram_rdata <= tb_mem[bram_addr[9:2]];
        end
    end

    // Reference model: who owns the port, how many locked beats it has taken,
    // who is favoured after a forced release, and whose turn it is.
    logic [DW-1:0] mdl_mem [256];
    bit            mdl_ready = 1'b0;
    int            m_owner = -1, m_beats = 0, m_fav = -1, m_rr = 0;
    bit [1:0]      m_rv = 2'b00;
    logic [DW-1:0] m_rd [2];
    logic [AW-1:0] c_a [2];
    logic [DW-1:0] c_wd [2];

    always @(negedge clk) begin
        bit [1:0]   r, l, wv, g;
        int         p, w;
        logic [3:0] exp_we;
        if (!mdl_ready) begin
            for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
            mdl_ready = 1'b1;
        end
        r = {m1_req, m0_req};
        l = {m1_lock, m0_lock};
        wv = {m1_we, m0_we};
        c_a[0] = m0_addr;  c_a[1] = m1_addr;
        c_wd[0] = m0_wdata; c_wd[1] = m1_wdata;
        if (!rst) begin
            chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
            chk("rst_en", bram_en, 1'b0);
            chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
            m_owner = -1; m_beats = 0; m_fav = -1; m_rr = 0; m_rv = 2'b00;
        end else begin
            g = 2'b00;
            if (m_owner >= 0) begin
                g[m_owner] = r[m_owner];
            end else begin
`ifdef BRAM_ARB_RR_EN
                p = (m_fav >= 0) ? m_fav : m_rr;
`else
                p = (m_fav >= 0) ? m_fav : 0;
`endif
                if (r[p]) g[p] = 1'b1;
                else if (r[1-p]) g[1-p] = 1'b1;
            end
            w = g[1] ? 1 : 0;
            exp_we = (g != 0 && wv[w]) ? 4'hF : 4'h0;
            chk("gnt", {m1_gnt, m0_gnt}, g);
            chk("bram_en", bram_en, g != 0);
            chk("bram_we", bram_we, exp_we);
            chk("bram_addr", bram_addr, (g != 0) ? c_a[w] : '0);
            chk("bram_wdata", bram_wdata, (g != 0) ? c_wd[w] : '0);
            chk("rvalid", {m1_rvalid, m0_rvalid}, m_rv);
            if (m_rv[0]) chk("m0_rdata", m0_rdata, m_rd[0]);
            if (m_rv[1]) chk("m1_rdata", m1_rdata, m_rd[1]);
            m_rv = 2'b00;
            if (g != 0) begin
                if (wv[w]) mdl_mem[c_a[w][9:2]] = c_wd[w];
                else begin
                    m_rv[w] = 1'b1;
                    m_rd[w] = mdl_mem[c_a[w][9:2]];
                end
                if (m_owner < 0) m_rr = 1 - w;
                if (l[w]) begin
                    m_beats++;
                    if (m_beats == LM) begin
                        m_owner = -1; m_beats = 0; m_fav = 1 - w;
                    end else begin
                        m_owner = w; m_fav = -1;
                    end
                end else begin
                    m_owner = -1; m_beats = 0; m_fav = -1;
                end
            end else begin
                m_fav = -1;
                if (m_owner >= 0 && !l[m_owner]) begin
                    m_owner = -1; m_beats = 0;
                end
            end
        end
    end

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic rnd(output logic req, output logic we, output logic lock,
                       output logic [AW-1:0] addr, output logic [DW-1:0] wd);
        req  = ($urandom_range(0, 3) != 0);
        we   = 1'($urandom_range(0, 1));
        lock = ($urandom_range(0, 2) == 0);
        addr = AW'($urandom_range(0, 15)) << 2;
        wd   = $urandom;
    endtask

    initial begin
        int  n0;
        bit  a0, a1;
        bit  is_m1;
        at_neg; at_neg;
        chk("reset_rvalid0", m0_rvalid, 1'b0);
        chk("reset_en", bram_en, 1'b0);
        to_drive;
        rst = 1;

        // 1: host write then core read of the same word
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hCAFE;
        at_neg;
        chk("t1_wr_gnt", m0_gnt, 1'b1);
        chk("t1_wr_we", bram_we, 4'hF);
        to_drive;
        idle_all;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        at_neg;
        chk("t1_rd_gnt", m1_gnt, 1'b1);
        chk("t1_rd_we", bram_we, 4'h0);
        to_drive;
        idle_all;
        at_neg;
        chk("t1_rvalid1", m1_rvalid, 1'b1);
        chk("t1_rdata", m1_rdata, 32'hCAFE);
        chk("t1_rvalid0", m0_rvalid, 1'b0);
        to_drive;
        at_neg;
        chk("t1_rvalid1_once", m1_rvalid, 1'b0);
        to_drive;

        // 2: both read every cycle, no lock
        m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            at_neg;
            chk("t2_one_gnt", {1'b0, m0_gnt} + {1'b0, m1_gnt}, 2'd1);
            n0 += int'(m0_gnt);
            to_drive;
        end
`ifdef BRAM_ARB_RR_EN
        chk("t2_m0_count", n0, 3);
`else
        chk("t2_m0_count", n0, 6);
`endif
        idle_all;
        to_drive;

        // 3: short locked host burst holds off the core
        m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h40; m0_wdata = 32'h1111;
        at_neg;
        chk("t3_first", m0_gnt, 1'b1);
        to_drive;
        m1_req = 1; m1_addr = 32'h44;
        m0_addr = 32'h44; m0_wdata = 32'h2222;
        at_neg;
        chk("t3_m1_blocked_a", m1_gnt, 1'b0);
        to_drive;
        m0_addr = 32'h48; m0_wdata = 32'h3333; m0_lock = 0;
        at_neg;
        chk("t3_m1_blocked_b", m1_gnt, 1'b0);
        to_drive;
        m0_req = 0; m0_we = 0;
        at_neg;
        chk("t3_m1_after", m1_gnt, 1'b1);
        to_drive;
        idle_all;
        to_drive;

        // 4: lock held forever hits the beat limit
        m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h80; m0_wdata = 32'hA0;
        for (int i = 0; i < 10; i++) begin
            at_neg;
            is_m1 = (i == 4 || i == 9);
            chk("t4_m1_gnt", m1_gnt, is_m1);
            chk("t4_m0_gnt", m0_gnt, !is_m1);
            to_drive;
            if (i == 0) begin
                m1_req = 1; m1_we = 0; m1_addr = 32'h84;
            end
            m0_addr = m0_addr + 4; m0_wdata = m0_wdata + 1;
        end
        idle_all;
        to_drive;

        // 5: reset right after an accepted read
        m0_req = 1; m0_addr = 32'h10;
        at_neg;
        chk("t5_rd_gnt", m0_gnt, 1'b1);
        to_drive;
        rst = 0; m0_req = 0; m1_req = 1; m1_addr = 32'h14;
        at_neg;
        chk("t5_no_rvalid", m0_rvalid, 1'b0);
        chk("t5_en_low", bram_en, 1'b0);
        chk("t5_m1_gnt_low", m1_gnt, 1'b0);
        to_drive;
        rst = 1; m0_req = 1;
        at_neg;
        chk("t5_first_m0", m0_gnt, 1'b1);
        chk("t5_first_m1", m1_gnt, 1'b0);
        to_drive;
        idle_all;
        to_drive;

        // 6: owner parks with lock and no request
        m1_req = 1; m1_lock = 1; m1_addr = 32'h30;
        at_neg;
        chk("t6_m1_gnt", m1_gnt, 1'b1);
        to_drive;
        m1_req = 0; m0_req = 1; m0_addr = 32'h34;
        for (int i = 0; i < 3; i++) begin
            at_neg;
            chk("t6_en_idle", bram_en, 1'b0);
            chk("t6_m0_held", m0_gnt, 1'b0);
            to_drive;
        end
        m1_lock = 0;
        at_neg;
        chk("t6_release_cycle", m0_gnt, 1'b0);
        to_drive;
        at_neg;
        chk("t6_m0_after", m0_gnt, 1'b1);
        to_drive;
        idle_all;
        to_drive;

        // Random traffic; requests are held until accepted.
        for (int c = 0; c < 800; c++) begin
            at_neg;
            a0 = m0_req && m0_gnt;
            a1 = m1_req && m1_gnt;
            to_drive;
            if (!rst) rst = 1;
            else if ($urandom_range(0, 149) == 0) rst = 0;
            if (!m0_req || a0) rnd(m0_req, m0_we, m0_lock, m0_addr, m0_wdata);
            if (!m1_req || a1) rnd(m1_req, m1_we, m1_lock, m1_addr, m1_wdata);
        end
        rst = 1;
        idle_all;
        for (int i = 0; i < 4; i++) to_drive;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
